exp_controller: RTL

EXP_CONTROLLER -- requirements
Module: exp_controller

---
 rtl/exp_controller.sv | 138 +++++++++++++
 1 files changed

// File: rtl/exp_controller.sv
// exp_controller: walks N_ITEMS operands through the exponent datapath,
// one at a time, and writes each result back to the result memory.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for go; err from the previous run stays visible
// READ   | operand address presented, synchronous memory access in flight
// CAPT   | operand word on rdData, captured into fracOut/uiOut
// LOAD   | datapath loads fraction and shift amount
// START  | one-cycle datapath start pulse, wait timer armed
// WAIT   | datapath shifting; leave on done or on timer expiry
// WRITE  | result strobed into result memory, advance or finish
// FINISH | one-cycle end-of-run pulse
module exp_controller #(
  parameter int N_ITEMS = 16,
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  output logic [ADDR_W-1:0] rdAddr,
  input  logic [6:0]        rdData,
  output logic [4:0]        fracOut,
  output logic [1:0]        uiOut,
  output logic              ld,
  output logic              uiRegLd,
  output logic              shEn,
  output logic              dpStart,
  input  logic              done,
  input  logic [20:0]       wrData,
  output logic [ADDR_W-1:0] wrAddr,
  output logic [20:0]       wrOut,
  output logic              wrEn,
  output logic              busy,
  output logic              finished,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE, READ, CAPT, LOAD, START, WAIT, WRITE, FINISH
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(N_ITEMS - 1);
  // The timer counts down so that expiry is a compare against zero;
  // loading TIMEOUT-1 gives exactly TIMEOUT cycles in WAIT.
  localparam logic [7:0]        WAIT_LOAD = 8'(TIMEOUT - 1);

  state_t            state;
  state_t            stateNext;
  logic [ADDR_W-1:0] idx;
  logic [7:0]        waitCnt;
  logic              waitTc;
  logic              lastItem;

  assign waitTc   = (waitCnt == 8'd0);
  assign lastItem = (idx == LAST_IDX);
  assign rdAddr   = idx;
  assign wrAddr   = idx;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Next-state decode; done takes priority over timer expiry in WAIT.
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (go) stateNext = READ;
      READ:    stateNext = CAPT;
      CAPT:    stateNext = LOAD;
      LOAD:    stateNext = START;
      START:   stateNext = WAIT;
      WAIT: begin
        if (done)        stateNext = WRITE;
        else if (waitTc) stateNext = FINISH;
      end
      WRITE:   stateNext = lastItem ? FINISH : READ;
      FINISH:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Moore control strobes decoded from the current state only.
  always_comb begin
    ld       = 1'b0;
    uiRegLd  = 1'b0;
    dpStart  = 1'b0;
    shEn     = 1'b0;
    wrEn     = 1'b0;
    finished = 1'b0;
    busy     = (state != IDLE);
    unique case (state)
      LOAD:    begin ld = 1'b1; uiRegLd = 1'b1; end
      START:   dpStart  = 1'b1;
      WAIT:    shEn     = 1'b1;
      WRITE:   wrEn     = 1'b1;
      FINISH:  finished = 1'b1;
      default: ;
    endcase
  end

  // Index, wait timer, operand/result registers and the sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      waitCnt <= '0;
      fracOut <= '0;
      uiOut   <= '0;
      wrOut   <= '0;
      err     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (go) begin
            idx <= '0;
            err <= 1'b0;
          end
        end
        CAPT: begin
          fracOut <= rdData[4:0];
          uiOut   <= rdData[6:5];
        end
        START: waitCnt <= WAIT_LOAD;
        WAIT: begin
          if (done)        wrOut   <= wrData;
          else if (waitTc) err     <= 1'b1;
          else             waitCnt <= waitCnt - 8'd1;
        end
        WRITE: if (!lastItem) idx <= idx + 1'b1;
        default: ;
      endcase
    end
  end

endmodule
